// File: rtl/axi4lite_mem_bridge.sv
// AXI4-Lite responder that turns each read or write into one request on the
// level-handshake memory bus, with byte strobes via read-modify-write and a response timeout.
module axi4lite_mem_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      AWvalid,
    output logic                      AWready,
    input  logic [ADDR_WIDTH-1:0]     AWdata,
    input  logic [2:0]                AWprot,
    input  logic                      Wvalid,
    output logic                      Wready,
    input  logic [DATA_WIDTH-1:0]     Wdata,
    input  logic [DATA_WIDTH/8-1:0]   Wstrb,
    output logic                      Bvalid,
    input  logic                      Bready,
    output logic [1:0]                Bresp,
    input  logic                      ARvalid,
    output logic                      ARready,
    input  logic [ADDR_WIDTH-1:0]     ARdata,
    input  logic [2:0]                ARprot,
    output logic                      Rvalid,
    input  logic                      RReady,
    output logic [DATA_WIDTH-1:0]     Rdata,
    output logic [1:0]                Rresp,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [ADDR_WIDTH-1:0]     mem_address,
    output logic [DATA_WIDTH-1:0]     mem_write_data,
    input  logic [DATA_WIDTH-1:0]     mem_read_data,
    input  logic                      mem_response
);

    // state  | meaning
    // IDLE   | accepting AW/W (latched independently) or AR
    // RMW_RD | fetching the old word for a partial-strobe write
    // WR     | memory write in flight
    // B_RESP | write response waiting for Bready
    // RD     | memory read in flight
    // R_RESP | read data waiting for RReady
    typedef enum logic [2:0] {IDLE, RMW_RD, WR, B_RESP, RD, R_RESP} state_t;

    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LOAD = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    state_t                 state;
    logic                   ready_en;
    logic                   aw_held;
    logic                   w_held;
    logic [ADDR_WIDTH-1:0]  aw_addr;
    logic [DATA_WIDTH-1:0]  w_data;
    logic [SW-1:0]          w_strb;
    logic [CW-1:0]          tmr;

    logic                   aw_fire;
    logic                   w_fire;
    logic                   ar_fire;
    logic                   aw_have;
    logic                   w_have;
    logic [ADDR_WIDTH-1:0]  addr_eff;
    logic [DATA_WIDTH-1:0]  data_eff;
    logic [SW-1:0]          strb_eff;
    logic                   timeout_hit;
    logic                   unused_ok;

    function automatic logic [ADDR_WIDTH-1:0] align(input logic [ADDR_WIDTH-1:0] a);
        return {a[ADDR_WIDTH-1:2], 2'b00};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] wr,
                                                          input logic [DATA_WIDTH-1:0] rd,
                                                          input logic [SW-1:0]         strb);
        logic [DATA_WIDTH-1:0] m;
        m = rd;
        for (int i = 0; i < SW; i++) begin
            if (strb[i]) m[8*i +: 8] = wr[8*i +: 8];
        end
        return m;
    endfunction

    // ready_en keeps every ready low while reset is asserted, even though the FSM sits in IDLE
    assign AWready = ready_en && (state == IDLE) && !aw_held;
    assign Wready  = ready_en && (state == IDLE) && !w_held;
    assign ARready = ready_en && (state == IDLE) && !aw_held && !w_held && !AWvalid && !Wvalid;

    assign aw_fire = AWvalid && AWready;
    assign w_fire  = Wvalid && Wready;
    assign ar_fire = ARvalid && ARready;
    assign aw_have = aw_held || aw_fire;
    assign w_have  = w_held || w_fire;

    assign addr_eff    = aw_held ? aw_addr : align(AWdata);
    assign data_eff    = w_held ? w_data : Wdata;
    assign strb_eff    = w_held ? w_strb : Wstrb;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmr == '0);
    assign unused_ok   = ^{AWprot, ARprot, AWdata[1:0], ARdata[1:0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            ready_en       <= 1'b0;
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            aw_addr        <= '0;
            w_data         <= '0;
            w_strb         <= '0;
            tmr            <= '0;
            Bvalid         <= 1'b0;
            Bresp          <= OKAY;
            Rvalid         <= 1'b0;
            Rdata          <= '0;
            Rresp          <= OKAY;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else begin
            ready_en <= 1'b1;
            if (aw_fire) begin
                aw_held <= 1'b1;
                aw_addr <= align(AWdata);
            end
            if (w_fire) begin
                w_held <= 1'b1;
                w_data <= Wdata;
                w_strb <= Wstrb;
            end
            case (state)
                IDLE: begin
                    // dispatch on the edge that completes the AW/W pair
                    if (aw_have && w_have) begin
                        mem_address    <= addr_eff;
                        mem_write_data <= data_eff;
                        if (&strb_eff) begin
                            state     <= WR;
                            mem_write <= 1'b1;
                            tmr       <= TO_LOAD;
                        end else if (strb_eff == '0) begin
                            state  <= B_RESP;
                            Bvalid <= 1'b1;
                            Bresp  <= OKAY;
                        end else begin
                            state    <= RMW_RD;
                            mem_read <= 1'b1;
                            tmr      <= TO_LOAD;
                        end
                    end else if (ar_fire) begin
                        state       <= RD;
                        mem_address <= align(ARdata);
                        mem_read    <= 1'b1;
                        tmr         <= TO_LOAD;
                    end
                end
                RMW_RD: begin
                    if (mem_response) begin
                        mem_write_data <= merge_bytes(mem_write_data, mem_read_data, w_strb);
                        mem_read       <= 1'b0;
                        mem_write      <= 1'b1;
                        tmr            <= TO_LOAD;
                        state          <= WR;
                    end else if (timeout_hit) begin
                        mem_read <= 1'b0;
                        Bvalid   <= 1'b1;
                        Bresp    <= SLVERR;
                        state    <= B_RESP;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                WR: begin
                    if (mem_response || timeout_hit) begin
                        mem_write <= 1'b0;
                        Bvalid    <= 1'b1;
                        Bresp     <= mem_response ? OKAY : SLVERR;
                        state     <= B_RESP;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                B_RESP: begin
                    if (Bready) begin
                        Bvalid  <= 1'b0;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                RD: begin
                    if (mem_response) begin
                        mem_read <= 1'b0;
                        Rdata    <= mem_read_data;
                        Rresp    <= OKAY;
                        Rvalid   <= 1'b1;
                        state    <= R_RESP;
                    end else if (timeout_hit) begin
                        mem_read <= 1'b0;
                        Rdata    <= '0;
                        Rresp    <= SLVERR;
                        Rvalid   <= 1'b1;
                        state    <= R_RESP;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                R_RESP: begin
                    if (RReady) begin
                        Rvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
